// File: rtl/gas_pkg.sv
// Shared encodings for the gas hazard FSM and the mitigation sequencer,
// kept together so log decoders read both states from one place.
package gas_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE         = 3'd0,
        SEQ_VALVE_SETTLE = 3'd1,
        SEQ_SPINUP       = 3'd2,
        SEQ_RUN          = 3'd3,
        SEQ_PURGE        = 3'd4,
        SEQ_FAULT        = 3'd5
    } seqState_t;

    // Hazard FSM states, as already used by the detector side.
    typedef enum logic [2:0] {
        HAZ_NORMAL  = 3'd0,
        HAZ_WARN    = 3'd1,
        HAZ_SHUTOFF = 3'd2,
        HAZ_VENT    = 3'd3,
        HAZ_LOCKOUT = 3'd4
    } hazState_t;

    localparam int unsigned SEQ_STATE_W = 3;

    // True on the cycle whose closing edge completes the requested tick count,
    // so a state lasts exactly ticks*TICK_DIV cycles after entry.
    function automatic logic timeoutReached(input int unsigned tickCnt,
                                            input logic        tick,
                                            input int unsigned ticks);
        return (tickCnt >= ticks) || (tick && ((tickCnt + 32'd1) == ticks));
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Prescaler plus saturating tick counter; clr restarts both so timing is
// measured from the cycle after clr.
module tick_timer #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             tick,
    output logic [CNT_W-1:0] tickCnt
);

    localparam logic [CNT_W-1:0] PRESCALE_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    logic [CNT_W-1:0] prescale;

    assign tick = (prescale == PRESCALE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            tickCnt  <= '0;
        end else if (clr) begin
            prescale <= '0;
            tickCnt  <= '0;
        end else begin
            prescale <= tick ? '0 : prescale + 1'b1;
            if (tick && (tickCnt != CNT_MAX)) begin
                tickCnt <= tickCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mitigation_sequencer.sv
// Turns steady valve/vent requests into a timed valve-close, fan spin-up,
// run and purge sequence, and reports mitigation health as mit_ok.
//
//   state        | meaning
//   IDLE         | no request, all drivers off
//   VALVE_SETTLE | valve closed, waiting for it to settle
//   SPINUP       | fan on, waiting for current/airflow feedback
//   RUN          | valve closed, fan follows req_vent, feedback filtered
//   PURGE        | requests gone, fan runs out before idling
//   FAULT        | feedback missing; hold drivers on until cleared
module mitigation_sequencer
    import gas_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 1000,
    parameter int unsigned VALVE_SETTLE   = 2,
    parameter int unsigned SPINUP_TIMEOUT = 5,
    parameter int unsigned FAN_RUNOUT     = 10,
    parameter int unsigned FAULT_FILT     = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valve,
    input  logic       req_vent,
    input  logic       fan_cur_ok,
    input  logic       air_ok,
    input  logic       fault_clr,
    output logic       valve_en,
    output logic       fan_en,
    output logic       mit_ok,
    output logic       busy,
    output logic [2:0] seq_state
);

    seqState_t        state;
    seqState_t        nextState;
    logic             stateClr;
    logic [1:0]       fanSync;
    logic [1:0]       airSync;
    logic             fbOk;
    logic             anyReq;
    logic             tick;
    logic [CNT_W-1:0] tickCnt;
    logic [CNT_W-1:0] filtCnt;
    logic             filtBad;
    logic             faultFilt;
    logic             fanPrev;
    logic             settleDone;
    logic             spinupDone;
    logic             runoutDone;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fanSync <= '0;
            airSync <= '0;
        end else begin
            fanSync <= {fanSync[0], fan_cur_ok};
            airSync <= {airSync[0], air_ok};
        end
    end

    assign fbOk   = fanSync[1] & airSync[1];
    assign anyReq = req_valve | req_vent;

    tick_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (stateClr),
        .tick    (tick),
        .tickCnt (tickCnt)
    );

    assign settleDone = timeoutReached(32'(tickCnt), tick, VALVE_SETTLE);
    assign spinupDone = timeoutReached(32'(tickCnt), tick, SPINUP_TIMEOUT);
    assign runoutDone = timeoutReached(32'(tickCnt), tick, FAN_RUNOUT);

    // Consecutive bad-feedback cycles while the fan is commanded in RUN.
    assign filtBad   = (state == SEQ_RUN) && req_vent && !fbOk;
    assign faultFilt = filtBad && ((32'(filtCnt) + 32'd1) >= FAULT_FILT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filtCnt <= '0;
        end else if (stateClr || !filtBad) begin
            filtCnt <= '0;
        end else if (filtCnt != '1) begin
            filtCnt <= filtCnt + 1'b1;
        end
    end

    // Remembers whether the fan was driven last cycle, which decides purge vs
    // direct idle and detects a vent request arriving in valve-only RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fanPrev <= 1'b0;
        end else begin
            fanPrev <= fan_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEQ_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        valve_en  = 1'b1;
        fan_en    = 1'b1;
        mit_ok    = 1'b0;
        busy      = 1'b1;
        case (state)
            SEQ_IDLE: begin
                valve_en = 1'b0;
                fan_en   = 1'b0;
                mit_ok   = 1'b1;
                busy     = 1'b0;
                if (anyReq) begin
                    nextState = SEQ_VALVE_SETTLE;
                end
            end
            SEQ_VALVE_SETTLE: begin
                fan_en = 1'b0;
                mit_ok = 1'b1;
                if (!anyReq) begin
                    nextState = SEQ_IDLE;
                end else if (settleDone) begin
                    nextState = req_vent ? SEQ_SPINUP : SEQ_RUN;
                end
            end
            SEQ_SPINUP: begin
                mit_ok = 1'b1;
                if (!anyReq) begin
                    nextState = SEQ_PURGE;
                end else if (fbOk) begin
                    nextState = SEQ_RUN;
                end else if (spinupDone) begin
                    nextState = SEQ_FAULT;
                end
            end
            SEQ_RUN: begin
                mit_ok = 1'b1;
                fan_en = req_vent;
                if (!anyReq) begin
                    nextState = fanPrev ? SEQ_PURGE : SEQ_IDLE;
                end else if (req_vent && !fanPrev) begin
                    nextState = SEQ_SPINUP;
                end else if (faultFilt) begin
                    nextState = SEQ_FAULT;
                end
            end
            SEQ_PURGE: begin
                valve_en = 1'b0;
                mit_ok   = 1'b1;
                if (anyReq) begin
                    nextState = SEQ_VALVE_SETTLE;
                end else if (runoutDone) begin
                    nextState = SEQ_IDLE;
                end
            end
            SEQ_FAULT: begin
                if (!anyReq) begin
                    nextState = SEQ_PURGE;
                end else if (fault_clr && fbOk) begin
                    nextState = SEQ_RUN;
                end
            end
            default: begin
                // Unknown code: drive as FAULT for one cycle, then recover.
                nextState = SEQ_IDLE;
            end
        endcase
    end

    assign stateClr  = (nextState != state);
    assign seq_state = state;

endmodule

// File: tb/tb_mitigation_sequencer.sv
// Bench for mitigation_sequencer: directed vector table, reset corner case,
// then random stimulus against a cycle-count reference model.
module tb_mitigation_sequencer;

    localparam int TD  = 4;
    localparam int VS  = 2;
    localparam int ST  = 3;
    localparam int FR  = 2;
    localparam int FF  = 3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_VS   = 3'd1;
    localparam logic [2:0] S_SP   = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_PU   = 3'd4;
    localparam logic [2:0] S_FA   = 3'd5;

    logic       clk;
    logic       rst;
    logic       reqValve;
    logic       reqVent;
    logic       fanCurOk;
    logic       airOk;
    logic       faultClr;
    logic       valveEn;
    logic       fanEn;
    logic       mitOk;
    logic       busy;
    logic [2:0] seqState;

    int nChecks = 0;
    int nFail   = 0;

    mitigation_sequencer #(
        .TICK_DIV       (TD),
        .VALVE_SETTLE   (VS),
        .SPINUP_TIMEOUT (ST),
        .FAN_RUNOUT     (FR),
        .FAULT_FILT     (FF),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valve  (reqValve),
        .req_vent   (reqVent),
        .fan_cur_ok (fanCurOk),
        .air_ok     (airOk),
        .fault_clr  (faultClr),
        .valve_en   (valveEn),
        .fan_en     (fanEn),
        .mit_ok     (mitOk),
        .busy       (busy),
        .seq_state  (seqState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       rv;
        logic       rve;
        logic       fc;
        logic       ao;
        logic       cl;
        int         waitCyc;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, rv, rve, fc, ao, cl, input int w,
                                input logic [2:0] st, input logic v, f, m, b);
        vec_t x;
        x.r = r; x.rv = rv; x.rve = rve; x.fc = fc; x.ao = ao; x.cl = cl;
        x.waitCyc = w;
        x.exp = {st, v, f, m, b};
        return x;
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {seqState, valveEn, fanEn, mitOk, busy};
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got state=%0d valve/fan/mit/busy=%b, expected state=%0d valve/fan/mit/busy=%b",
                     name, act[6:4], act[3:0], exp[6:4], exp[3:0]);
        end
    endtask

    // Reference model: time in state counted in plain cycles, feedback as a
    // two-cycle-old copy of the pins.
    int   mState;
    int   mCyc;
    int   mStreak;
    logic mFanPrev;
    logic mP1;
    logic mP2;

    task automatic modelReset();
        mState = 0; mCyc = 0; mStreak = 0; mFanPrev = 1'b0; mP1 = 1'b0; mP2 = 1'b0;
    endtask

    function automatic logic [6:0] modelOut(input logic r, input logic rve);
        if (r) return {S_IDLE, 4'b0010};
        case (mState)
            0:       return {S_IDLE, 4'b0010};
            1:       return {S_VS,   4'b1011};
            2:       return {S_SP,   4'b1111};
            3:       return {S_RUN,  1'b1, rve, 2'b11};
            4:       return {S_PU,   4'b0111};
            default: return {S_FA,   4'b1101};
        endcase
    endfunction

    task automatic modelStep(input logic r, rv, rve, fc, ao, cl, input logic fanNow);
        int   nxt;
        logic anyR;
        logic fb;
        logic bad;
        if (r) begin
            modelReset();
        end else begin
            anyR = rv | rve;
            fb   = mP2;
            nxt  = mState;
            bad  = (mState == 3) && rve && !fb;
            case (mState)
                0: if (anyR) nxt = 1;
                1: if (!anyR) nxt = 0;
                   else if (mCyc == VS*TD - 1) nxt = rve ? 2 : 3;
                2: if (!anyR) nxt = 4;
                   else if (fb) nxt = 3;
                   else if (mCyc == ST*TD - 1) nxt = 5;
                3: if (!anyR) nxt = mFanPrev ? 4 : 0;
                   else if (rve && !mFanPrev) nxt = 2;
                   else if (bad && (mStreak + 1 >= FF)) nxt = 5;
                4: if (anyR) nxt = 1;
                   else if (mCyc == FR*TD - 1) nxt = 0;
                default: if (!anyR) nxt = 4;
                   else if (cl && fb) nxt = 3;
            endcase
            if (nxt != mState) begin
                mCyc = 0; mStreak = 0;
            end else begin
                mCyc++;
                mStreak = bad ? mStreak + 1 : 0;
            end
            mState   = nxt;
            mFanPrev = fanNow;
            mP2      = mP1;
            mP1      = fc & ao;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected the bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fcPct;
        int aoPct;
        logic [6:0] e;

        rst = 1'b1; reqValve = 1'b0; reqVent = 1'b0;
        fanCurOk = 1'b1; airOk = 1'b1; faultClr = 1'b0;

        //               r  rv rve fc ao cl wait state  v  f  m  b
        // nominal sequence
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 2, S_IDLE, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 3, S_IDLE, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, S_VS,   1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 7, S_VS,   1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, S_SP,   1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, S_RUN,  1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 5, S_RUN,  1, 1, 1, 1));
        // spin-up timeout, then clear attempts
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, S_IDLE, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2, S_IDLE, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 1, S_VS,   1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 8, S_SP,   1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 11, S_SP,  1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 1, S_FA,   1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 2, S_FA,   1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 3, S_FA,   1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 1, S_RUN,  1, 1, 1, 1));
        // running fault filter
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 2, S_RUN,  1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 4, S_RUN,  1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 4, S_RUN,  1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, S_FA,   1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 2, S_FA,   1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 2, S_FA,   1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 1, S_RUN,  1, 1, 1, 1));
        // purge and re-request
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, S_PU,   0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 7, S_PU,   0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, S_IDLE, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, S_VS,   1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 8, S_SP,   1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, S_RUN,  1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, S_PU,   0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 3, S_PU,   0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, S_VS,   1, 0, 1, 1));
        // valve-only request
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 8, S_RUN,  1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 2, S_RUN,  1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, S_SP,   1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, S_RUN,  1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, S_RUN,  1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, S_IDLE, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 3, S_IDLE, 0, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].r; reqValve = vecs[i].rv; reqVent = vecs[i].rve;
            fanCurOk = vecs[i].fc; airOk = vecs[i].ao; faultClr = vecs[i].cl;
            repeat (vecs[i].waitCyc) @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // asynchronous reset in the middle of spin-up
        rst = 1'b1; reqValve = 1'b0; reqVent = 1'b0; fanCurOk = 1'b0; airOk = 1'b1; faultClr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; reqValve = 1'b1; reqVent = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        check("reset_pre_spinup", {S_SP, 4'b1111});
        #2;
        rst = 1'b1; reqValve = 1'b0; reqVent = 1'b0;
        #2;
        check("reset_async_outputs", {S_IDLE, 4'b0010});
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("reset_stays_idle", {S_IDLE, 4'b0010});
        reqValve = 1'b1;
        @(posedge clk); #1;
        check("reset_then_request", {S_VS, 4'b1011});

        // randomized run against the reference model
        rst = 1'b1; reqValve = 1'b0; reqVent = 1'b0; faultClr = 1'b0;
        fanCurOk = 1'b1; airOk = 1'b1;
        @(posedge clk); #1;
        modelReset();
        fcPct = 100; aoPct = 100;
        for (int i = 0; i < 4000; i++) begin
            if (i % 60 == 0) begin
                case ($urandom_range(0, 4))
                    0, 1:    fcPct = 100;
                    2:       fcPct = 90;
                    3:       fcPct = 50;
                    default: fcPct = 0;
                endcase
                aoPct = ($urandom_range(0, 2) == 0) ? 80 : 100;
            end
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 24) == 0) reqValve = ~reqValve;
            if ($urandom_range(0, 29) == 0) reqVent = ~reqVent;
            fanCurOk = ($urandom_range(0, 99) < fcPct);
            airOk    = ($urandom_range(0, 99) < aoPct);
            faultClr = ($urandom_range(0, 7) == 0);
            #1;
            e = modelOut(rst, reqVent);
            check("random", e);
            modelStep(rst, reqValve, reqVent, fanCurOk, airOk, faultClr, e[2]);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
